ahb2apb_bridge: RTL and testbench
=================================

Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB (APB3, with pready/pslverr) master bridge.
- Converts each AHB NONSEQ/SEQ transfer into one APB SETUP+ACCESS transfer.
- Stalls the AHB data phase with hreadyout until the APB transfer completes.
- Sits between the system AHB interconnect and a single APB peripheral segment.

Parameters:
- ADDR_W, 32, width of haddr and paddr.
- DATA_W, 32, width of hwdata/hrdata/pwdata/prdata.

Ports:
- hclk  in  1  bus clock; all logic is on its rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  AHB slave select.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  AHB transfer type; bit1=1 means a valid transfer.
- hwrite  in  1  1 = write.
- hsize  in  3  accepted and ignored; always a full-word access.
- hwdata  in  DATA_W  write data, valid in the AHB data phase.
- hready  in  1  bus-level ready; an address is sampled only when it is 1.
- hreadyout  out  1  bridge ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_W  read data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (async, hreset=1):
  - state=IDLE; hreadyout=1, hresp=0, hrdata=0.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - Reset mid-transfer aborts it immediately.
- Transfer accept condition: hsel & htrans[1] & hready, evaluated in IDLE, DONE or ERR2.
  - On accept, haddr is registered into paddr and hwrite into pwrite.
  - IDLE/BUSY htrans, or hsel=0, are ignored and give a zero-wait OKAY.
- States, all registered outputs:
  - IDLE: hreadyout=1, psel=0. Accepted read -> SETUP. Accepted write -> WDATA.
  - WDATA: hreadyout=0. Registers hwdata into pwdata. -> SETUP.
  - SETUP: psel=1, penable=0, hreadyout=0. -> ACCESS.
  - ACCESS: psel=1, penable=1, hreadyout=0. Holds while pready=0, with paddr/pwrite/pwdata stable.
    - pready=1 and pslverr=0: for reads, register prdata into hrdata; -> DONE.
    - pready=1 and pslverr=1: -> ERR1.
  - DONE: psel=0, penable=0, hreadyout=1, hresp=0. Accepts a new transfer (pipelined), otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1. -> ERR2.
  - ERR2: hreadyout=1, hresp=1. Accepts a new transfer like DONE, otherwise -> IDLE.
- Latency, with T0 = AHB address-phase cycle and zero-wait APB:
  - Read: SETUP at T1, ACCESS at T2, hreadyout=1 with hrdata valid at T3.
  - Write: WDATA at T1, SETUP at T2, ACCESS at T3, hreadyout=1 at T4.
  - Each pready=0 cycle adds one cycle.
- hrdata holds its last read value until the next read completes; writes do not alter it.
- psel deasserts for at least one cycle between back-to-back APB transfers (the DONE/ERR2 cycle).
- paddr/pwrite/pwdata hold their last values while idle.

Test Plan:
- Single write, zero-wait APB: haddr=0x0000_0010, hwdata=0xA5A5_1234 → psel rises at T2, penable at T3 with paddr=0x10, pwrite=1, pwdata=0xA5A5_1234; hreadyout low T1–T3, high T4; hresp=0.
- Single read: haddr=0x0000_0020, prdata=0xDEAD_BEEF, pready=1 → SETUP at T1, ACCESS at T2; hrdata=0xDEAD_BEEF with hreadyout=1 at T3.
- APB wait states: a read with pready held low for 3 ACCESS cycles → penable high for 4 cycles, paddr stable; hreadyout returns 1 one cycle after pready=1.
- Error: write with pslverr=1 at pready → hresp=1/hreadyout=0 for one cycle, then hresp=1/hreadyout=1; a following read completes OKAY.
- Random mix: 5 back-to-back read/write transfers at random addresses, random 0–5 pready delays → each APB access matches the AHB address/data order, and read data returns to hrdata in order.
- Reset: assert hreset during ACCESS → psel=penable=0 and hreadyout=1 immediately; the next transfer after release proceeds normally.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB SETUP+ACCESS transfer per AHB NONSEQ/SEQ transfer.
// Latency: read completes at T3 and write at T4 (T0 = address phase); each APB wait state adds one cycle.
// Backpressure: hreadyout is held low until the APB transfer completes. pready=0 holds the ACCESS phase.
//
// Ports:
//   hclk, hreset                     clock (rising edge) and asynchronous active-high reset
//   hsel/haddr/htrans/hwrite/hsize   AHB address phase (hsize ignored, always full word)
//   hwdata                           AHB write data (data phase)
//   hready                           bus-level ready; an address is sampled only when it is high
//   hreadyout/hresp/hrdata           AHB data-phase response (all registered)
//   psel/penable/pwrite/paddr/pwdata APB master request (all registered)
//   prdata/pready/pslverr            APB completer response
module ahb2apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic accept;
  logic unused_ok;

  // Only NONSEQ/SEQ to this slave, qualified by the bus-level ready, start a transfer.
  assign accept    = hsel & htrans[1] & hready;
  // Transfer size and the NONSEQ/SEQ distinction do not affect the APB side.
  assign unused_ok = ^{hsize, htrans[0]};

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      // DONE and ERR2 end a data phase with hreadyout=1, so a pipelined
      // address can be accepted in the same cycle, exactly as from IDLE.
      S_IDLE, S_DONE, S_ERR2: begin
        penable_d = 1'b0;
        hresp_d   = 1'b0;
        if (accept) begin
          paddr_d     = haddr;
          pwrite_d    = hwrite;
          hreadyout_d = 1'b0;
          if (hwrite) begin
            // Write data only arrives in the next (data-phase) cycle.
            state_d = S_WDATA;
            psel_d  = 1'b0;
          end else begin
            state_d = S_SETUP;
            psel_d  = 1'b1;
          end
        end else begin
          state_d     = S_IDLE;
          hreadyout_d = 1'b1;
          psel_d      = 1'b0;
        end
      end

      S_WDATA: begin
        pwdata_d    = hwdata;
        state_d     = S_SETUP;
        psel_d      = 1'b1;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pslverr) begin
            // Two-cycle ERROR response: first cycle with hreadyout low.
            state_d     = S_ERR1;
            hresp_d     = 1'b1;
            hreadyout_d = 1'b0;
          end else begin
            state_d     = S_DONE;
            hresp_d     = 1'b0;
            hreadyout_d = 1'b1;
            if (!pwrite_q) begin
              hrdata_d = prdata;
            end
          end
        end
      end

      S_ERR1: begin
        state_d     = S_ERR2;
        hresp_d     = 1'b1;
        hreadyout_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Testbench for ahb2apb_bridge: pipelined AHB master, APB completer with per-transfer
// wait states / errors / read data, and a transaction-level expectation of responses.
// Cycle-level behaviour is checked from a per-cycle trace of the bridge outputs.
module tb_ahb2apb_bridge;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXN = 8;
  localparam int TRN  = 1024;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hready_lo;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  // Single-slave bus: bus-level ready follows the bridge, optionally forced low.
  assign hready = hreadyout & ~hready_lo;

  always #5 hclk = ~hclk;

  ahb2apb_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Per-cycle trace of the registered outputs, indexed by cycle number.
  int   cyc = 0;
  logic tr_psel [TRN];
  logic tr_pen  [TRN];
  logic tr_rdy  [TRN];
  logic tr_resp [TRN];

  always @(posedge hclk) cyc <= cyc + 1;

  always @(negedge hclk) begin
    tr_psel[cyc % TRN] = psel;
    tr_pen[cyc % TRN]  = penable;
    tr_rdy[cyc % TRN]  = hreadyout;
    tr_resp[cyc % TRN] = hresp;
  end

  function automatic int ti(input int c);
    return c % TRN;
  endfunction

  // Transfer list: AHB order, APB completer behaviour and read data for each entry.
  logic [AW-1:0] sq_addr  [MAXN];
  logic          sq_wr    [MAXN];
  logic [DW-1:0] sq_wdata [MAXN];
  logic [DW-1:0] sq_rdata [MAXN];
  int            sq_delay [MAXN];
  logic          sq_err   [MAXN];
  int            sq_n    = 0;
  int            apb_idx = 0;
  logic [DW-1:0] last_rd = '0;
  int            t0      = 0;

  task automatic set_xfer(input int i, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          input int d, input logic e);
    sq_addr[i]  = a;
    sq_wr[i]    = w;
    sq_wdata[i] = wd;
    sq_rdata[i] = rd;
    sq_delay[i] = d;
    sq_err[i]   = e;
  endtask

  // APB completer: drives pready after sq_delay wait cycles and checks that
  // each APB access carries the next AHB transfer's address/direction/data.
  logic          in_acc = 1'b0;
  int            wcnt   = 0;
  logic [AW-1:0] acc_addr;

  always begin
    step();
    if (psel && penable) begin
      if (!in_acc) begin
        in_acc   = 1'b1;
        wcnt     = 0;
        acc_addr = paddr;
      end else begin
        wcnt++;
        chk("paddr_stable", paddr, acc_addr);
      end
      if (apb_idx >= sq_n) begin
        chk("apb_extra_psel", psel, 1'b0);
        pready  = 1'b1;
        pslverr = 1'b0;
      end else if (wcnt >= sq_delay[apb_idx]) begin
        chk("apb_addr", paddr, sq_addr[apb_idx]);
        chk("apb_write", pwrite, sq_wr[apb_idx]);
        if (sq_wr[apb_idx]) chk("apb_wdata", pwdata, sq_wdata[apb_idx]);
        pready  = 1'b1;
        pslverr = sq_err[apb_idx];
        prdata  = sq_rdata[apb_idx];
        apb_idx++;
      end else begin
        pready  = 1'b0;
        pslverr = $urandom_range(0, 1);
        prdata  = $urandom;
      end
    end else begin
      in_acc  = 1'b0;
      pready  = 1'b0;
      pslverr = $urandom_range(0, 1);
      prdata  = $urandom;
    end
  end

  // Pipelined AHB master over sq[0..n-1]: address of i+1 overlaps data phase of i.
  // Expected response: hresp follows the completer error; hrdata is the data of the
  // most recent read that completed without error.
  task automatic run_seq(input int n);
    sq_n    = n;
    apb_idx = 0;
    t0      = cyc;
    for (int i = 0; i <= n; i++) begin
      int waitc = 0;
      if (i < n) begin
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = sq_addr[i];
        hwrite = sq_wr[i];
        hsize  = 3'($urandom_range(0, 2));
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
      end
      while (!hready && waitc < 100) begin
        step();
        waitc++;
      end
      if (waitc >= 100) chk("hready_timeout", hready, 1'b1);
      if (i > 0) begin
        chk("hresp", hresp, sq_err[i-1]);
        if (!sq_wr[i-1] && !sq_err[i-1]) last_rd = sq_rdata[i-1];
        chk("hrdata", hrdata, last_rd);
      end
      step();
      if (i < n && sq_wr[i]) hwdata = sq_wdata[i];
      else                   hwdata = $urandom;
    end
    chk("apb_count", apb_idx, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    int npen;
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hwdata = '0; hready_lo = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step(); step();
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    hreset = 1'b0;
    step();

    // Single write, zero-wait APB.
    set_xfer(0, 32'h0000_0010, 1'b1, 32'hA5A5_1234, 32'h0, 0, 1'b0);
    run_seq(1);
    chk("wr_psel_T1", tr_psel[ti(t0+1)], 1'b0);
    chk("wr_psel_T2", tr_psel[ti(t0+2)], 1'b1);
    chk("wr_pen_T2",  tr_pen[ti(t0+2)],  1'b0);
    chk("wr_pen_T3",  tr_pen[ti(t0+3)],  1'b1);
    chk("wr_rdy_T1",  tr_rdy[ti(t0+1)],  1'b0);
    chk("wr_rdy_T3",  tr_rdy[ti(t0+3)],  1'b0);
    chk("wr_rdy_T4",  tr_rdy[ti(t0+4)],  1'b1);
    chk("wr_resp_T4", tr_resp[ti(t0+4)], 1'b0);

    // Single read, zero-wait APB.
    set_xfer(0, 32'h0000_0020, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_seq(1);
    chk("rd_psel_T1", tr_psel[ti(t0+1)], 1'b1);
    chk("rd_pen_T1",  tr_pen[ti(t0+1)],  1'b0);
    chk("rd_pen_T2",  tr_pen[ti(t0+2)],  1'b1);
    chk("rd_rdy_T2",  tr_rdy[ti(t0+2)],  1'b0);
    chk("rd_rdy_T3",  tr_rdy[ti(t0+3)],  1'b1);

    // Read with three APB wait states.
    set_xfer(0, 32'h0000_0124, 1'b0, 32'h0, 32'h0BAD_F00D, 3, 1'b0);
    run_seq(1);
    npen = 0;
    for (int k = 0; k < 10; k++) npen += int'(tr_pen[ti(t0+k)]);
    chk("ws_pen_cycles", npen, 4);
    chk("ws_rdy_T5", tr_rdy[ti(t0+5)], 1'b0);
    chk("ws_rdy_T6", tr_rdy[ti(t0+6)], 1'b1);

    // Write with slave error, then a read that completes OKAY.
    set_xfer(0, 32'h0000_0200, 1'b1, 32'h1357_9BDF, 32'h0, 0, 1'b1);
    set_xfer(1, 32'h0000_0204, 1'b0, 32'h0, 32'h2468_ACE0, 0, 1'b0);
    run_seq(2);
    chk("err_rdy_T4",  tr_rdy[ti(t0+4)],  1'b0);
    chk("err_resp_T4", tr_resp[ti(t0+4)], 1'b1);
    chk("err_rdy_T5",  tr_rdy[ti(t0+5)],  1'b1);
    chk("err_resp_T5", tr_resp[ti(t0+5)], 1'b1);
    chk("err_psel_T6", tr_psel[ti(t0+6)], 1'b1);

    // Unselected, BUSY and hready-low addresses are not transfers.
    sq_n = 0; apb_idx = 0; t0 = cyc;
    hsel = 1'b0; htrans = 2'b10; haddr = 32'h300; step(); step();
    hsel = 1'b1; htrans = 2'b01; step(); step();
    htrans = 2'b10; hready_lo = 1'b1; step(); step();
    hready_lo = 1'b0; hsel = 1'b0; htrans = 2'b00; step(); step();
    for (int k = 1; k < 8; k++) begin
      chk("ign_psel", tr_psel[ti(t0+k)], 1'b0);
      chk("ign_rdy",  tr_rdy[ti(t0+k)],  1'b1);
    end

    // Randomized back-to-back bursts of five; errors in the later rounds.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 5; i++) begin
        logic e;
        e = (r >= 10) && ($urandom_range(0, 7) == 0);
        set_xfer(i, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 $urandom_range(0, 5), e);
      end
      run_seq(5);
    end

    // Reset asserted during ACCESS aborts the transfer at once.
    sq_n = 1; apb_idx = 0;
    set_xfer(0, 32'h0000_0040, 1'b0, 32'h0, 32'h1234_5678, 5, 1'b0);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b0;
    step();
    hsel = 1'b0; htrans = 2'b00;
    waitc = 0;
    while (!(psel && penable) && waitc < 20) begin
      step();
      waitc++;
    end
    chk("rst_reach_access", penable, 1'b1);
    step();
    hreset = 1'b1;
    #1;
    chk("arst_psel", psel, 1'b0);
    chk("arst_penable", penable, 1'b0);
    chk("arst_hreadyout", hreadyout, 1'b1);
    chk("arst_hresp", hresp, 1'b0);
    step();
    hreset = 1'b0;
    last_rd = '0;
    chk("arst_hrdata", hrdata, 32'h0);
    step();
    set_xfer(0, 32'h0000_0044, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
    run_seq(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
